// File: rtl/writeback_irq.sv
// writeback_irq: writeback stage with prioritised interrupts, WFI sleep and instret counter
module writeback_irq #(
  parameter int XLEN = 32,
  parameter int NUM_IRQ = 3,
  parameter logic [NUM_IRQ*4-1:0] IRQ_CAUSE = {4'd3, 4'd7, 4'd11},
  parameter int RET_CNT_W = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 valid_in,
  input  logic [XLEN-1:0]      pc_in,
  input  logic [XLEN-1:0]      next_pc_in,
  input  logic [XLEN-1:0]      alu_data_in,
  input  logic [XLEN-1:0]      csr_data_in,
  input  logic [XLEN-1:0]      load_data_in,
  input  logic [1:0]           write_select_in,
  input  logic [4:0]           rd_address_in,
  input  logic                 mret_in,
  input  logic                 wfi_in,
  input  logic                 exception_in,
  input  logic [3:0]           ecause_in,
  input  logic [NUM_IRQ-1:0]   irq_in,
  output logic [4:0]           rd_address,
  output logic [XLEN-1:0]      rd_data,
  output logic                 traped,
  output logic                 mret,
  output logic                 retired,
  output logic [3:0]           ecause,
  output logic                 interupt,
  output logic [XLEN-1:0]      ecp,
  output logic                 stall_wfi,
  output logic [RET_CNT_W-1:0] instret
);
  localparam logic [1:0] WRITE_SEL_ALU = 2'd0;
  localparam logic [1:0] WRITE_SEL_CSR = 2'd1;
  localparam logic [1:0] WRITE_SEL_LOAD = 2'd2;
  typedef enum logic {S_RUN, S_WAIT} state_t;
  state_t state_q, state_d;
  logic [XLEN-1:0] resume_pc_q, resume_pc_d;
  logic [RET_CNT_W-1:0] instret_q, instret_d;
  logic irq_hit, in_wait;
  logic [3:0] irq_cause;
  always_comb begin
    irq_cause = 4'd0;
    // Scan downwards so the lowest set index is the last, winning, assignment
    for (int i = NUM_IRQ - 1; i >= 0; i--)
      if (irq_in[i]) irq_cause = IRQ_CAUSE[4*i +: 4];
    irq_hit = |irq_in;
    in_wait = state_q == S_WAIT;
    traped = in_wait ? irq_hit : valid_in & (irq_hit | exception_in);
    interupt = in_wait ? irq_hit : valid_in & irq_hit;
    ecause = interupt ? irq_cause : traped ? ecause_in : 4'd0;
    ecp = in_wait ? resume_pc_q : wfi_in ? next_pc_in : pc_in;
    retired = ~in_wait & valid_in & ~traped;
    mret = mret_in & retired;
    rd_address = retired ? rd_address_in : 5'd0;
    rd_data = write_select_in == WRITE_SEL_ALU ? alu_data_in :
              write_select_in == WRITE_SEL_CSR ? csr_data_in :
              write_select_in == WRITE_SEL_LOAD ? load_data_in : next_pc_in;
    state_d = in_wait ? (irq_hit ? S_RUN : S_WAIT) : (retired & wfi_in ? S_WAIT : S_RUN);
    resume_pc_d = retired & wfi_in ? next_pc_in : resume_pc_q;
    instret_d = instret_q + RET_CNT_W'(retired);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= S_RUN;
      resume_pc_q <= '0;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      resume_pc_q <= resume_pc_d;
      instret_q <= instret_d;
    end
  assign stall_wfi = state_q == S_WAIT;
  assign instret = instret_q;
endmodule

// File: tb/tb_writeback_irq.sv
// tb_writeback_irq: directed scenarios plus random traffic against a behavioural model
module tb_writeback_irq;
  logic clk = 0, reset = 1;
  logic valid_in = 0, mret_in = 0, wfi_in = 0, exception_in = 0;
  logic [31:0] pc_in = 0, next_pc_in = 0, alu_data_in = 0, csr_data_in = 0, load_data_in = 0;
  logic [1:0] write_select_in = 0;
  logic [4:0] rd_address_in = 0;
  logic [3:0] ecause_in = 0;
  logic [2:0] irq_in = 0;
  logic [4:0] rd_address;
  logic [31:0] rd_data, ecp;
  logic traped, mret, retired, interupt, stall_wfi;
  logic [3:0] ecause, instret;
  int checks = 0, failures = 0;

  writeback_irq #(.XLEN(32), .NUM_IRQ(3), .RET_CNT_W(4)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .pc_in(pc_in), .next_pc_in(next_pc_in),
    .alu_data_in(alu_data_in), .csr_data_in(csr_data_in), .load_data_in(load_data_in),
    .write_select_in(write_select_in), .rd_address_in(rd_address_in), .mret_in(mret_in),
    .wfi_in(wfi_in), .exception_in(exception_in), .ecause_in(ecause_in), .irq_in(irq_in),
    .rd_address(rd_address), .rd_data(rd_data), .traped(traped), .mret(mret),
    .retired(retired), .ecause(ecause), .interupt(interupt), .ecp(ecp),
    .stall_wfi(stall_wfi), .instret(instret));

  always #5 clk = ~clk;

  int cause_tab [3] = '{11, 7, 3};
  bit m_wait = 0;
  logic [31:0] m_resume = 0;
  int m_cnt = 0;
  logic e_traped, e_int, e_ret, e_mret;
  logic [3:0] e_cause;
  logic [31:0] e_ecp, e_rd_data;
  logic [4:0] e_rd_addr;

  task automatic predict();
    int win = -1;
    for (int i = 0; i < 3; i++) if (irq_in[i] && win < 0) win = i;
    if (m_wait) begin
      e_traped = win >= 0; e_int = win >= 0; e_ecp = m_resume; e_ret = 0;
    end else begin
      e_int = valid_in && win >= 0;
      e_traped = valid_in && (win >= 0 || exception_in);
      e_ecp = wfi_in ? next_pc_in : pc_in;
      e_ret = valid_in && !e_traped;
    end
    e_cause = e_int ? 4'(cause_tab[win]) : e_traped ? ecause_in : 4'd0;
    e_mret = mret_in && e_ret;
    e_rd_addr = e_ret ? rd_address_in : 5'd0;
    case (write_select_in)
      2'd0: e_rd_data = alu_data_in;
      2'd1: e_rd_data = csr_data_in;
      2'd2: e_rd_data = load_data_in;
      default: e_rd_data = next_pc_in;
    endcase
  endtask

  task automatic advance();
    predict();
    @(posedge clk);
    if (m_wait && e_traped) m_wait = 0;
    else if (!m_wait && e_ret && wfi_in) begin m_wait = 1; m_resume = next_pc_in; end
    if (e_ret) m_cnt = (m_cnt + 1) % 16;
    #1;
  endtask

  task automatic set_idle();
    valid_in = 0; mret_in = 0; wfi_in = 0; exception_in = 0; irq_in = 0;
    ecause_in = 0; write_select_in = 0;
  endtask

  task automatic test_reset();
    #12;
    checks++; if (stall_wfi !== 1'b0) begin failures++; $display("FAIL reset_stall got=%0b exp=0", stall_wfi); end
    checks++; if (instret !== 4'd0) begin failures++; $display("FAIL reset_instret got=%0d exp=0", instret); end
    checks++; if ({traped, retired, mret, interupt, ecause, rd_address} !== 13'd0) begin
      failures++; $display("FAIL reset_comb got=%b exp=0", {traped, retired, mret, interupt, ecause, rd_address}); end
    reset = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_alu_write();
    set_idle(); valid_in = 1; alu_data_in = 32'h1234; rd_address_in = 5; pc_in = 32'h40;
    #1;
    checks++; if (rd_address !== 5'd5 || rd_data !== 32'h1234 || retired !== 1'b1 || traped !== 1'b0) begin
      failures++; $display("FAIL alu_write got=%0d/%h/%0b/%0b exp=5/1234/1/0", rd_address, rd_data, retired, traped); end
    checks++; if (instret !== 4'd0) begin failures++; $display("FAIL alu_instret_pre got=%0d exp=0", instret); end
    advance();
    checks++; if (instret !== 4'd1) begin failures++; $display("FAIL alu_instret_post got=%0d exp=1", instret); end
  endtask

  task automatic test_priority();
    set_idle(); valid_in = 1; irq_in = 3'b110; exception_in = 1; ecause_in = 2; pc_in = 32'h80;
    mret_in = 1;
    #1;
    checks++; if (traped !== 1'b1 || interupt !== 1'b1 || ecause !== 4'd7 || rd_address !== 5'd0 || ecp !== 32'h80 || mret !== 1'b0) begin
      failures++; $display("FAIL priority got=%0b/%0b/%0d/%0d/%h/%0b exp=1/1/7/0/80/0", traped, interupt, ecause, rd_address, ecp, mret); end
    advance();
    checks++; if (instret !== 4'd1) begin failures++; $display("FAIL priority_instret got=%0d exp=1", instret); end
    irq_in = 0; #1;
    checks++; if (traped !== 1'b1 || interupt !== 1'b0 || ecause !== 4'd2) begin
      failures++; $display("FAIL exc_only got=%0b/%0b/%0d exp=1/0/2", traped, interupt, ecause); end
    advance();
  endtask

  task automatic test_bubble();
    set_idle(); irq_in = 3'b001; #1;
    checks++; if (traped !== 1'b0 || retired !== 1'b0 || ecause !== 4'd0) begin
      failures++; $display("FAIL bubble got=%0b/%0b/%0d exp=0/0/0", traped, retired, ecause); end
    advance();
    valid_in = 1; pc_in = 32'h100; next_pc_in = 32'h104; #1;
    checks++; if (traped !== 1'b1 || ecause !== 4'd11 || ecp !== 32'h100 || interupt !== 1'b1) begin
      failures++; $display("FAIL bubble_irq got=%0b/%0d/%h exp=1/11/100", traped, ecause, ecp); end
    advance();
  endtask

  task automatic test_wfi_sleep();
    set_idle(); valid_in = 1; wfi_in = 1; pc_in = 32'h200; next_pc_in = 32'h204; #1;
    checks++; if (retired !== 1'b1 || traped !== 1'b0 || stall_wfi !== 1'b0) begin
      failures++; $display("FAIL wfi_retire got=%0b/%0b/%0b exp=1/0/0", retired, traped, stall_wfi); end
    advance();
    set_idle();
    for (int k = 0; k < 5; k++) begin
      valid_in = k[0]; mret_in = 1; pc_in = $urandom; next_pc_in = $urandom; #1;
      checks++; if (stall_wfi !== 1'b1 || retired !== 1'b0 || traped !== 1'b0 || mret !== 1'b0 || rd_address !== 5'd0) begin
        failures++; $display("FAIL wfi_hold cyc=%0d got=%0b/%0b/%0b/%0b exp=1/0/0/0", k, stall_wfi, retired, traped, mret); end
      advance();
    end
    set_idle(); irq_in = 3'b100; #1;
    checks++; if (traped !== 1'b1 || ecause !== 4'd3 || ecp !== 32'h204 || interupt !== 1'b1 || stall_wfi !== 1'b1) begin
      failures++; $display("FAIL wfi_wake got=%0b/%0d/%h/%0b exp=1/3/204/1", traped, ecause, ecp, stall_wfi); end
    advance();
    irq_in = 0; #1;
    checks++; if (stall_wfi !== 1'b0) begin failures++; $display("FAIL wfi_resume got=%0b exp=0", stall_wfi); end
  endtask

  task automatic test_wfi_pending();
    set_idle(); valid_in = 1; wfi_in = 1; irq_in = 3'b001; pc_in = 32'h300; next_pc_in = 32'h304; #1;
    checks++; if (traped !== 1'b1 || ecp !== 32'h304 || ecause !== 4'd11 || retired !== 1'b0) begin
      failures++; $display("FAIL wfi_pending got=%0b/%h/%0d/%0b exp=1/304/11/0", traped, ecp, ecause, retired); end
    advance();
    set_idle(); #1;
    checks++; if (stall_wfi !== 1'b0) begin failures++; $display("FAIL wfi_pending_run got=%0b exp=0", stall_wfi); end
  endtask

  task automatic test_reset_in_wait();
    set_idle(); valid_in = 1; wfi_in = 1; next_pc_in = 32'h404;
    advance();
    set_idle(); #1;
    checks++; if (stall_wfi !== 1'b1) begin failures++; $display("FAIL rst_wait_enter got=%0b exp=1", stall_wfi); end
    #2 reset = 1;
    #1;
    m_wait = 0; m_resume = 0; m_cnt = 0;
    checks++; if (stall_wfi !== 1'b0 || instret !== 4'd0) begin
      failures++; $display("FAIL rst_wait got=%0b/%0d exp=0/0", stall_wfi, instret); end
    #2 reset = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_wrap();
    set_idle(); valid_in = 1;
    for (int k = 0; k < 17; k++) begin
      rd_address_in = 5'($urandom); advance();
    end
    checks++; if (instret !== 4'd1) begin failures++; $display("FAIL wrap got=%0d exp=1", instret); end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      valid_in = $urandom_range(0, 3) != 0; mret_in = $urandom_range(0, 3) == 0;
      wfi_in = $urandom_range(0, 5) == 0; exception_in = !m_wait && $urandom_range(0, 5) == 0;
      ecause_in = 4'($urandom); irq_in = $urandom_range(0, 3) == 0 ? 3'($urandom) : 3'd0;
      pc_in = $urandom; next_pc_in = $urandom; alu_data_in = $urandom; csr_data_in = $urandom;
      load_data_in = $urandom; write_select_in = 2'($urandom); rd_address_in = 5'($urandom);
      #1; predict();
      checks++; if ({traped, interupt, ecause, retired, mret} !== {e_traped, e_int, e_cause, e_ret, e_mret}) begin
        failures++; $display("FAIL rand_ctrl cyc=%0d got=%b exp=%b", k, {traped, interupt, ecause, retired, mret}, {e_traped, e_int, e_cause, e_ret, e_mret}); end
      checks++; if (ecp !== e_ecp || rd_address !== e_rd_addr || rd_data !== e_rd_data) begin
        failures++; $display("FAIL rand_data cyc=%0d got=%h/%0d/%h exp=%h/%0d/%h", k, ecp, rd_address, rd_data, e_ecp, e_rd_addr, e_rd_data); end
      checks++; if (stall_wfi !== m_wait || instret !== 4'(m_cnt)) begin
        failures++; $display("FAIL rand_state cyc=%0d got=%0b/%0d exp=%0b/%0d", k, stall_wfi, instret, m_wait, m_cnt); end
      advance();
    end
  endtask

  initial begin
    test_reset();
    test_alu_write();
    test_priority();
    test_bubble();
    test_wfi_sleep();
    test_wfi_pending();
    test_reset_in_wait();
    test_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/writeback_irq.md
# writeback_irq

Parametrised writeback stage with interrupt arbitration, a WFI wait state and an instruction-retire counter. It sits at the end of the pipeline, after memory. It selects and drives the register-file write and decides trap or retire for the instruction leaving the pipeline. It drives cause, interrupt flag and exception PC to csr, and trap and mret to fetch and hazard. It generalises the fixed three-interrupt writeback to NUM_IRQ prioritised sources and adds WFI sleeping and an internal instret count.

## Interface
Parameters:
- XLEN, 32, data and PC width.
- NUM_IRQ, 3, interrupt sources. Index 0 has the highest priority.
- IRQ_CAUSE, {4'd3,4'd7,4'd11}, packed NUM_IRQ×4 cause codes. Source i uses bits [4i+3:4i]. The default maps source 0 to 11, source 1 to 7, source 2 to 3.
- RET_CNT_W, 64, width of the instret counter.

Ports:
- clk, in, 1: the single clock.
- reset, in, 1: asynchronous, active-high reset.
- valid_in, in, 1: the memory-stage instruction is valid.
- pc_in, next_pc_in, in, XLEN each: PC of the instruction and its sequential successor.
- alu_data_in, csr_data_in, load_data_in, in, XLEN each: candidate rd values.
- write_select_in, in, 2: selects rd_data as ALU, CSR, LOAD or NEXT_PC.
- rd_address_in, in, 5: destination register.
- mret_in, wfi_in, in, 1 each: instruction is mret or wfi.
- exception_in, in, 1: synchronous exception.
- ecause_in, in, 4: cause code of that exception.
- irq_in, in, NUM_IRQ: level interrupt requests, already enable-masked by csr.
- rd_address, out, 5: register-file write address. 0 means no write.
- rd_data, out, XLEN: register-file write data.
- traped, out, 1: a trap is taken this cycle.
- mret, out, 1: an mret is taken this cycle.
- retired, out, 1: an instruction retires this cycle.
- ecause, out, 4: trap cause code.
- interupt, out, 1: the trap is an interrupt.
- ecp, out, XLEN: PC saved to mepc.
- stall_wfi, out, 1: the core is sleeping in WFI. Upstream holds valid_in at 0 while this is high.
- instret, out, RET_CNT_W: count of retired instructions.

## Operation
State machine:
- Two states, RUN and WAIT. Reset enters RUN.

Interrupt arbitration:
- irq_hit is the OR of all irq_in bits.
- The winner is the lowest set index i. Its cause is IRQ_CAUSE[i].

Trap and retire in RUN:
- An interrupt is taken only when valid_in=1, so ecp always refers to a real instruction.
- traped = valid_in & (irq_hit | exception_in).
- Interrupt priority is higher than exception priority.
  - On an interrupt: interupt=1, ecause = the winner's cause.
  - On an exception only: interupt=0, ecause = ecause_in.
  - With no trap: ecause=0, interupt=0.
- ecp = wfi_in ? next_pc_in : pc_in.
- retired = valid_in & ~traped.
- mret = mret_in & retired.
- A retiring wfi moves the state to WAIT. It also latches next_pc_in into the resume_pc register.
- A wfi that meets a pending interrupt traps with ecp=next_pc_in. It does not enter WAIT.

Behaviour in WAIT:
- valid_in is ignored.
- retired=0 and mret=0.
- traped = irq_hit, with interupt=1 and ecause = the winner's cause.
- ecp = resume_pc.
- A taken trap returns the state to RUN.
- Exceptions cannot occur in WAIT.

Register-file write:
- rd_address = retired ? rd_address_in : 0.
- rd_data is muxed by write_select_in using the existing WRITE_SEL_* encodings. It is valid regardless of retired.

instret:
- Increments by 1 on every cycle where retired=1.
- Wraps modulo 2^RET_CNT_W.

## Timing
- All outputs except stall_wfi and instret are combinational from the inputs and current state, with zero latency.
- stall_wfi = (state==WAIT). It is registered and rises the cycle after the wfi retires.
- On the wake cycle, stall_wfi=1 and traped=1. stall_wfi falls on the next clock edge.
- Minimum sleep is one cycle in WAIT. An irq asserted in the first WAIT cycle wakes the core in that cycle.
- instret updates on the clock edge following a retire.

Reset values (asynchronous):
- state=RUN, stall_wfi=0, resume_pc=0, instret=0.
- Combinational outputs follow the inputs. With valid_in=0 they are rd_address=0, traped=0, retired=0, mret=0, ecause=0, interupt=0.
- Reset asserted mid-WAIT returns immediately to RUN and drops stall_wfi.

Simultaneous events:
- Several irq bits set at once: the lowest index wins.
- irq together with an exception: the interrupt wins, with interupt=1.
- irq together with mret: the trap wins, so mret=0.

## Test plan
- ALU write, no trap: valid=1, write_select=ALU, alu_data=0x1234, rd=5 → rd_address=5, rd_data=0x1234, retired=1, instret 0→1 next cycle.
- Priority: irq_in=3'b110 with exception_in=1 and ecause_in=2 → traped=1, interupt=1, ecause=7 (source 1), rd_address=0, ecp=pc_in, instret unchanged.
- Bubble: valid_in=0, irq_in=3'b001 → traped=0 and retired=0. Then valid_in=1 with pc 0x100 → traped, ecause=11, ecp=0x100.
- WFI sleep and wake: wfi retires at pc 0x200 (next_pc 0x204) → stall_wfi=1 next cycle. Hold 5 cycles with valid_in toggling → no retire, no trap. Set irq_in[2] → traped=1, ecause=3, ecp=0x204 that cycle, stall_wfi=0 next cycle.
- WFI with a pending irq: wfi_in=1, valid=1, irq_in[0]=1 → traped, ecp=next_pc_in, state stays RUN.
- Reset in WAIT and counter wrap: assert reset while stall_wfi=1 → stall_wfi=0 and instret=0 immediately. With RET_CNT_W=4, 17 retires → instret=1.
